// File: rtl/spi_cmd_pkg.sv
// Shared opcode, state and constant definitions for the SPI command sequencer.
package spi_cmd_pkg;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int A16_BIT = 0;
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

  typedef enum logic [1:0] {
    WRITE_AT   = 2'b00,
    READ_AT    = 2'b01,
    WRITE_NEXT = 2'b10,
    READ_NEXT  = 2'b11
  } op_t;

  // Raw encodings kept as plain constants so checkers can compare against bits.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_WB_WR   = 3'd4;
  localparam logic [2:0] ST_WB_RD   = 3'd5;
  localparam logic [2:0] ST_DRAIN   = 3'd6;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ADDR_HI = ST_ADDR_HI,
    ADDR_LO = ST_ADDR_LO,
    DATA    = ST_DATA,
    WB_WR   = ST_WB_WR,
    WB_RD   = ST_WB_RD,
    DRAIN   = ST_DRAIN
  } state_t;

  function automatic logic op_is_read(input op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_wb_timeout.sv
// Ack watchdog: counts clocks while a Wishbone cycle waits and pulses on expiry.
module wb_timeout #(
  parameter int CYCLES = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = run_i ? cnt_q + CW'(1) : '0;
  end

  // Fires on the last allowed waiting clock so cyc drops after exactly CYCLES clocks.
  assign expired_o = run_i && (cnt_q == CW'(CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI byte stream to Wishbone master sequencer with address auto-increment.
// Optional ack timeout enabled by defining SPI_CMD_TIMEOUT_EN.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  spi_cs_ni,
  input  logic                  rx_valid_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  output logic                  busy_o,
  output logic                  overrun_o
);

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic                  a16_q, a16_d;
  logic [DATA_WIDTH-1:0] ahi_q, ahi_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic                  ovr_q, ovr_d;
  logic                  cs_q, cs_d;

  logic byte_ok;
  logic wb_done;
  logic tmo_expired;

`ifdef SPI_CMD_TIMEOUT_EN
  wb_timeout #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_wb_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .run_i     (cyc_q && !wb_ack_i),
    .expired_o (tmo_expired)
  );
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a16_d   = a16_q;
    ahi_d   = ahi_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tx_d    = tx_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    ovr_d   = ovr_q;
    cs_d    = spi_cs_ni;

    // A byte on the same clock as chip select rising is ignored.
    byte_ok = rx_valid_i && !spi_cs_ni;
    wb_done = cyc_q && (wb_ack_i || tmo_expired);

    if (cs_q && !spi_cs_ni) ovr_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (byte_ok) begin
          op_d  = op_t'(rx_data_i[OP_MSB:OP_LSB]);
          a16_d = rx_data_i[A16_BIT];
          case (op_t'(rx_data_i[OP_MSB:OP_LSB]))
            WRITE_AT, READ_AT: state_d = ADDR_HI;
            WRITE_NEXT:        state_d = DATA;
            default: begin
              state_d = WB_RD;
              cyc_d   = 1'b1;
              we_d    = 1'b0;
            end
          endcase
        end
      end
      ADDR_HI: begin
        if (spi_cs_ni) state_d = IDLE;
        else if (byte_ok) begin
          ahi_d   = rx_data_i;
          state_d = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (spi_cs_ni) state_d = IDLE;
        else if (byte_ok) begin
          adr_d = ADDR_WIDTH'({a16_q, ahi_q, rx_data_i});
          if (op_q == WRITE_AT) state_d = DATA;
          else begin
            state_d = WB_RD;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
          end
        end
      end
      DATA: begin
        if (spi_cs_ni) state_d = IDLE;
        else if (byte_ok) begin
          cyc_d = 1'b1;
          if (op_is_read(op_q)) begin
            state_d = WB_RD;
            we_d    = 1'b0;
          end else begin
            dat_d   = rx_data_i;
            state_d = WB_WR;
            we_d    = 1'b1;
          end
        end
      end
      WB_WR, WB_RD, DRAIN: begin
        if (byte_ok) ovr_d = 1'b1;
        if (wb_done) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          adr_d = adr_q + ADDR_WIDTH'(1);
          if (wb_ack_i) begin
            if (!we_q) tx_d = wb_dat_i;
          end else begin
            if (!we_q) tx_d = DATA_WIDTH'(TIMEOUT_FILL);
            ovr_d = 1'b1;
          end
          state_d = (spi_cs_ni || state_q == DRAIN) ? IDLE : DATA;
        end else if (spi_cs_ni) begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= WRITE_AT;
      a16_q   <= 1'b0;
      ahi_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      tx_q    <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      ovr_q   <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a16_q   <= a16_d;
      ahi_q   <= ahi_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      tx_q    <= tx_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      ovr_q   <= ovr_d;
      cs_q    <= cs_d;
    end
  end

  assign tx_data_o = tx_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign busy_o    = cyc_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl with a Wishbone slave model and transaction scoreboard.
module tb_spi_cmd_ctrl;
  import spi_cmd_pkg::*;

  localparam int GAP = 10;

  logic        clk;
  logic        rst_ni;
  logic        spi_cs_ni;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic [7:0]  tx_data_o;
  logic [16:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        busy_o;
  logic        overrun_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:131071];
  logic [25:0] exp_q[$];
  int          ack_delay = 2;
  logic        ack_hold  = 1'b0;

  spi_cmd_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .spi_cs_ni  (spi_cs_ni),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .tx_data_o  (tx_data_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] txn(input logic we, input logic [16:0] adr, input logic [7:0] dat);
    return {we, adr, dat};
  endfunction

  // Wishbone slave: acks after ack_delay clocks and scores each completed cycle
  initial begin : slave
    int          wait_cnt;
    logic [25:0] e;
    wait_cnt = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      wb_ack_i = 1'b0;
      if (wb_cyc_o && wb_stb_o && !ack_hold) begin
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          if (exp_q.size() == 0) begin
            check("wb_unexpected_cycle", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("wb_we", wb_we_o, e[25]);
            check("wb_adr", wb_adr_o, e[24:8]);
            if (e[25]) check("wb_wdat", wb_dat_o, e[7:0]);
          end
          if (wb_we_o) mem[wb_adr_o] = wb_dat_o;
          else         wb_dat_i = mem[wb_adr_o];
          wb_ack_i = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Driver tasks: all start and end 1 time unit after a rising edge
  task automatic pulse_rx(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse_rx(b);
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    spi_cs_ni = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic cs_high();
    spi_cs_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && wb_cyc_o; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, wb_cyc_o, 1'b0);
  endtask

  initial begin : main
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h08000] = 8'h12;
    mem[17'h08001] = 8'h34;
    mem[17'h08002] = 8'h56;
    mem[17'h08003] = 8'h78;
    mem[17'h08004] = 8'h9A;
    mem[17'h10010] = 8'hE7;
    rst_ni     = 1'b0;
    spi_cs_ni  = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);
    check("rst_adr", wb_adr_o, 17'h0);
    check("rst_tx", tx_data_o, 8'h00);
    check("rst_state", dut.state_q, ST_IDLE);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // WRITE_AT 1_8000 with two data bytes
    exp_q.push_back(txn(1'b1, 17'h18000, 8'hAA));
    exp_q.push_back(txn(1'b1, 17'h18001, 8'h55));
    cs_low();
    send_byte(8'h01);
    send_byte(8'h80);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'h55);
    cs_high();
    check("wr_state_idle", dut.state_q, ST_IDLE);
    check("wr_final_adr", wb_adr_o, 17'h18002);
    check("wr_overrun", overrun_o, 1'b0);

    // READ_AT 0_8000 with two dummy bytes
    cs_low();
    send_byte(8'h40);
    send_byte(8'h80);
    exp_q.push_back(txn(1'b0, 17'h08000, 8'h00));
    send_byte(8'h00);
    check("rd_tx_first", tx_data_o, 8'h12);
    exp_q.push_back(txn(1'b0, 17'h08001, 8'h00));
    send_byte(8'hA5);
    check("rd_tx_second", tx_data_o, 8'h34);
    exp_q.push_back(txn(1'b0, 17'h08002, 8'h00));
    send_byte(8'h5A);
    check("rd_tx_third", tx_data_o, 8'h56);
    cs_high();
    check("rd_final_adr", wb_adr_o, 17'h08003);

    // READ_NEXT continues from the persisted address
    cs_low();
    exp_q.push_back(txn(1'b0, 17'h08003, 8'h00));
    send_byte(8'hC0);
    check("rdn_tx_first", tx_data_o, 8'h78);
    exp_q.push_back(txn(1'b0, 17'h08004, 8'h00));
    send_byte(8'h00);
    check("rdn_tx_second", tx_data_o, 8'h9A);
    cs_high();
    check("rdn_final_adr", wb_adr_o, 17'h08005);

    // Address wrap from 1_FFFF
    cs_low();
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'hFF);
    exp_q.push_back(txn(1'b1, 17'h1FFFF, 8'h5A));
    send_byte(8'h5A);
    cs_high();
    check("wrap_adr", wb_adr_o, 17'h00000);

    // Overrun with a slow slave, then chip select rising mid-cycle
    ack_delay = 20;
    cs_low();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back(txn(1'b1, 17'h00100, 8'hC3));
    pulse_rx(8'hC3);
    repeat (3) @(posedge clk);
    #1;
    pulse_rx(8'h77);
    check("ovr_set", overrun_o, 1'b1);
    check("ovr_busy", busy_o, 1'b1);
    cs_high();
    check("drain_state", dut.state_q, ST_DRAIN);
    check("drain_cyc", wb_cyc_o, 1'b1);
    wait_idle("drain_complete", 40);
    check("drain_to_idle", dut.state_q, ST_IDLE);
    check("drain_adr", wb_adr_o, 17'h00101);
    check("ovr_sticky", overrun_o, 1'b1);
    ack_delay = 2;
    cs_low();
    check("ovr_clear_on_cs_fall", overrun_o, 1'b0);
    cs_high();

    // Reset while a read waits for ack
    ack_hold = 1'b1;
    cs_low();
    send_byte(8'hC0);
    check("rst_mid_busy", busy_o, 1'b1);
    check("rst_mid_state", dut.state_q, ST_WB_RD);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_cyc", wb_cyc_o, 1'b0);
    check("rst_mid_stb", wb_stb_o, 1'b0);
    check("rst_mid_idle", dut.state_q, ST_IDLE);
    check("rst_mid_tx", tx_data_o, 8'h00);
    check("rst_mid_adr", wb_adr_o, 17'h0);
    rst_ni = 1'b1;
    cs_high();
    ack_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Withheld ack on READ_AT 1_0010
    ack_hold = 1'b1;
    cs_low();
    send_byte(8'h41);
    send_byte(8'h00);
    pulse_rx(8'h10);
`ifdef SPI_CMD_TIMEOUT_EN
    repeat (10) @(posedge clk);
    #1;
    check("tmo_cyc_still_high", wb_cyc_o, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("tmo_cyc_dropped", wb_cyc_o, 1'b0);
    check("tmo_tx_fill", tx_data_o, 8'hFF);
    check("tmo_overrun", overrun_o, 1'b1);
    check("tmo_adr", wb_adr_o, 17'h10011);
    check("tmo_state", dut.state_q, ST_DATA);
    ack_hold = 1'b0;
`else
    repeat (30) @(posedge clk);
    #1;
    check("noto_cyc_held", wb_cyc_o, 1'b1);
    check("noto_state", dut.state_q, ST_WB_RD);
    check("noto_overrun", overrun_o, 1'b0);
    exp_q.push_back(txn(1'b0, 17'h10010, 8'h00));
    ack_hold = 1'b0;
    wait_idle("noto_complete", 20);
    check("noto_tx", tx_data_o, 8'hE7);
    check("noto_adr", wb_adr_o, 17'h10011);
`endif
    cs_high();
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Sequencer in the system clock domain that turns the byte stream from the SPI Mode 0 shift core into Wishbone master cycles on the shared PET bus.
- Parses command frames (opcode, address, data) delimited by chip select.
- Issues reads and writes with address auto-increment.
- Stages the response byte the shift core transmits on the next transfer.
- Sits between the CDC synchronizer (SCK→clk) and the Wishbone interconnect.

Parameters:
ADDR_WIDTH, 17, Wishbone address width; bit 16 is carried in command byte bit 0.
DATA_WIDTH, 8, SPI byte and Wishbone data width.
TIMEOUT_CYCLES, 15, clk cycles to wait for ack before abort (used only with the optional feature).

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  synchronous, active-low reset.
spi_cs_ni  in  1  chip select, already synchronized to clk_i; high = no frame.
rx_valid_i  in  1  one-cycle pulse: rx_data_i holds a complete received byte (synchronized strobe).
rx_data_i  in  DATA_WIDTH  received byte.
tx_data_o  out  DATA_WIDTH  byte to present to the shift core for the next transfer.
wb_adr_o  out  ADDR_WIDTH  Wishbone address.
wb_dat_o  out  DATA_WIDTH  write data.
wb_dat_i  in  DATA_WIDTH  read data.
wb_we_o  out  1  write enable.
wb_cyc_o  out  1  cycle.
wb_stb_o  out  1  strobe.
wb_ack_i  in  1  acknowledge.
busy_o  out  1  Wishbone cycle in flight.
overrun_o  out  1  sticky: byte arrived while busy; cleared at frame start.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - State IDLE.
  - All outputs 0; wb_adr_o=0; tx_data_o=8'h00.
  - Reset overrides everything, including an in-flight Wishbone cycle: cyc/stb drop the next cycle.
- Command byte layout:
  - [7:6] op: 00 WRITE_AT, 01 READ_AT, 10 WRITE_NEXT, 11 READ_NEXT.
  - [5:1] reserved, ignored.
  - [0] address bit A16.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, WB_WR, WB_RD, DRAIN.
- IDLE:
  - Entered, and overrun_o cleared, on the clk where synchronized spi_cs_ni falls.
  - First rx_valid latches op and A16.
  - *_AT ops go to ADDR_HI. WRITE_NEXT goes to DATA. READ_NEXT goes to WB_RD immediately.
- Address bytes:
  - ADDR_HI latches A15:8 and goes to ADDR_LO.
  - ADDR_LO latches A7:0. WRITE_AT then goes to DATA; READ_AT goes to WB_RD.
- DATA:
  - Write ops: each rx_valid latches wb_dat_o and goes to WB_WR.
  - Read ops: each rx_valid (dummy byte) goes to WB_RD as a prefetch of the next address.
- WB_WR / WB_RD:
  - Assert cyc, stb and busy the cycle after entry; we=1 only for WB_WR.
  - Hold until wb_ack_i. Deassert cyc/stb on the ack cycle +1.
  - Address increments by 1, modulo 2^ADDR_WIDTH (1FFFF wraps to 00000).
  - On a read ack, tx_data_o <= wb_dat_i.
  - Then go to DATA.
- tx_data_o timing: updates only on a read ack; otherwise it holds its value. The first read result is therefore what the host receives on the byte after the last address/command byte.
- Overrun: rx_valid while in WB_WR/WB_RD:
  - The byte is dropped and overrun_o is set.
  - The cycle completes normally.
- spi_cs_ni rising:
  - With no cycle in flight: go to IDLE at the next clk.
  - Mid Wishbone cycle: go to DRAIN. The cycle completes, then IDLE. The address is still incremented; tx_data_o is updated.
- The address register persists across frames, so *_NEXT ops continue from the last address.
- Simultaneous events:
  - rx_valid on the same clk as spi_cs_ni rising: the byte is ignored.
  - spi_cs_ni falling while in DRAIN: the new frame starts after the drain completes, and bytes that arrive during the drain set overrun_o.

Optional Feature:
- Macro: SPI_CMD_TIMEOUT_EN.
- Defined:
  - A counter starts when cyc asserts.
  - If ack is absent for TIMEOUT_CYCLES clks, cyc/stb drop and overrun_o is set.
  - On a read timeout, tx_data_o <= 8'hFF.
  - The address still increments and the state returns as for an ack.
- Not defined: the block waits indefinitely for ack; no counter logic is synthesized.

Decomposition:
- Package spi_cmd_pkg holds:
  - op_t enum: WRITE_AT, READ_AT, WRITE_NEXT, READ_NEXT.
  - state_t enum.
  - Constants: OP_MSB=7, OP_LSB=6, A16_BIT=0, TIMEOUT_FILL=8'hFF.
- One sub-module, wb_timeout: counter plus expiry pulse, instantiated only under SPI_CMD_TIMEOUT_EN. All other logic lives in the top FSM.

Test Plan:
- Write: frame 8'h01,8'h80,8'h00,8'hAA,8'h55 → Wishbone writes AA@1_8000 and 55@1_8001 (we=1); final wb_adr_o=1_8002.
- Read: memory 8000=8'h12, 8001=8'h34; frame 8'h40,8'h80,8'h00,dummy,dummy → tx_data_o=12 after the addr_lo read ack, then 34 after the first dummy; final address 8003.
- Continue: following READ_NEXT frame (8'hC0, dummy) → reads 8003, with no address bytes sent.
- Wrap: WRITE_AT address 1_FFFF, data 8'h5A → write at 1FFFF; wb_adr_o becomes 0_0000.
- Overrun and abort:
  - Slave withholds ack 20 clks while a second rx_valid arrives → overrun_o=1, byte dropped.
  - spi_cs_ni rising mid-cycle → cycle completes after ack, then IDLE.
  - Next spi_cs_ni fall clears overrun_o.
- Reset and timeout:
  - rst_ni low during WB_RD → cyc/stb=0 the next clk, state IDLE, tx_data_o=00.
  - With SPI_CMD_TIMEOUT_EN and no ack → cyc drops after 15 clks, tx_data_o=FF, overrun_o=1.
